// File: rtl/fsm_chan_enable_ctrl_if.sv
// Control-side bundle for the channel enable controller: per-channel
// requests and datapath busy flags in, channel enables and status out.
interface fsm_chan_enable_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int TO_W   = 8
);
  logic [NUM_CH-1:0] ip_enable;
  logic [NUM_CH-1:0] req_disable;
  logic [NUM_CH-1:0] busy;
  logic [TO_W-1:0]   timeout_cfg;
  logic [NUM_CH-1:0] err_clr;
  logic [NUM_CH-1:0] enabled;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] idle;
  logic [NUM_CH-1:0] timeout_err;
  logic              all_idle;

  // Register/control block side
  modport master (
    output ip_enable, req_disable, busy, timeout_cfg, err_clr,
    input  enabled, ack, idle, timeout_err, all_idle
  );

  // Controller side
  modport slave (
    input  ip_enable, req_disable, busy, timeout_cfg, err_clr,
    output enabled, ack, idle, timeout_err, all_idle
  );
endinterface

// File: rtl/fsm_chan_enable_ctrl.sv
// Multi-channel enable/disable handshake controller. Each channel runs an
// independent IDLE -> ENABLE -> DRAIN -> DISABLE -> IDLE machine; the drain
// wait is bounded by a shared timeout and a timeout leaves a sticky error.
module fsm_chan_enable_ctrl #(
  parameter int NUM_CH = 4,
  parameter int TO_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fsm_chan_enable_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ENABLE  = 2'b01,
    DRAIN   = 2'b10,
    DISABLE = 2'b11
  } state_e;

  logic [NUM_CH-1:0] enabled_vec;
  logic [NUM_CH-1:0] ack_vec;
  logic [NUM_CH-1:0] idle_vec;
  logic [NUM_CH-1:0] err_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_e          state_q, state_d;
      logic [TO_W-1:0] cnt_q, cnt_d;
      logic            err_q, err_d;
      logic            set_err;

      // State, drain counter and sticky error registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          err_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          err_q   <= err_d;
        end
      end

      // Next-state logic; the drain counter saturates so that an unbounded
      // wait (timeout_cfg == 0, or a cfg lowered below cnt) never wraps
      // back into a spurious timeout match.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set_err = 1'b0;
        case (state_q)
          IDLE: begin
            if (bus.ip_enable[gi]) state_d = ENABLE;
          end
          ENABLE: begin
            if (bus.req_disable[gi]) begin
              state_d = DRAIN;
              cnt_d   = '0;
            end
          end
          DRAIN: begin
            if (!bus.busy[gi]) begin
              state_d = DISABLE;
            end else if ((bus.timeout_cfg != '0) &&
                         (cnt_q == bus.timeout_cfg - TO_W'(1))) begin
              state_d = DISABLE;
              set_err = 1'b1;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + TO_W'(1);
            end
          end
          DISABLE: begin
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase

        // A new timeout takes priority over a coincident clear
        if (set_err) begin
          err_d = 1'b1;
        end else if (bus.err_clr[gi]) begin
          err_d = 1'b0;
        end else begin
          err_d = err_q;
        end
      end

      // Moore outputs; the datapath stays enabled while draining
      assign enabled_vec[gi] = (state_q == ENABLE) || (state_q == DRAIN);
      assign ack_vec[gi]     = (state_q == DISABLE);
      assign idle_vec[gi]    = (state_q == IDLE);
      assign err_vec[gi]     = err_q;
    end
  endgenerate

  assign bus.enabled     = enabled_vec;
  assign bus.ack         = ack_vec;
  assign bus.idle        = idle_vec;
  assign bus.timeout_err = err_vec;
  assign bus.all_idle    = &idle_vec;

endmodule

// File: tb/tb_fsm_chan_enable_ctrl.sv
// Directed bench for fsm_chan_enable_ctrl: a 4-channel/8-bit instance for
// handshake, drain, timeout and reset cases, and a 1-channel/4-bit instance
// for the unbounded-drain saturation boundary.
module tb_fsm_chan_enable_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsm_chan_enable_ctrl_if #(.NUM_CH(4), .TO_W(8)) m();
  fsm_chan_enable_ctrl_if #(.NUM_CH(1), .TO_W(4)) m4();

  fsm_chan_enable_ctrl #(.NUM_CH(4), .TO_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  fsm_chan_enable_ctrl #(.NUM_CH(1), .TO_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (m4)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Expected status word: {all_idle, timeout_err, idle, ack, enabled}
  function automatic logic [31:0] st(input logic [3:0] en, input logic [3:0] ak,
                                     input logic [3:0] id, input logic [3:0] er);
    return {15'b0, &id, er, id, ak, en};
  endfunction

  function automatic logic [31:0] st1(input logic en, input logic ak,
                                      input logic id, input logic er);
    return {27'b0, id, er, id, ak, en};
  endfunction

  function automatic logic [31:0] obs_main();
    return {15'b0, m.all_idle, m.timeout_err, m.idle, m.ack, m.enabled};
  endfunction

  function automatic logic [31:0] obs_small();
    return {27'b0, m4.all_idle, m4.timeout_err, m4.idle, m4.ack, m4.enabled};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
      $display("check %-16s observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m.ip_enable = '0; m.req_disable = '0; m.busy = '0;
    m.timeout_cfg = '0; m.err_clr = '0;
    m4.ip_enable = '0; m4.req_disable = '0; m4.busy = '0;
    m4.timeout_cfg = '0; m4.err_clr = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    push("reset", st(4'h0, 4'h0, 4'hF, 4'h0));
    tick();
    compare(obs_main());

    // Basic handshake on ch1
    m.ip_enable[1] = 1'b1;
    push("ch1_enable", st(4'h2, 4'h0, 4'hD, 4'h0));
    tick();
    m.ip_enable[1] = 1'b0;
    compare(obs_main());
    push("ch1_hold", st(4'h2, 4'h0, 4'hD, 4'h0));
    tick();
    compare(obs_main());
    m.req_disable[1] = 1'b1;
    push("ch1_drain", st(4'h2, 4'h0, 4'hD, 4'h0));
    tick();
    m.req_disable[1] = 1'b0;
    compare(obs_main());
    push("ch1_ack", st(4'h0, 4'h2, 4'hD, 4'h0));
    tick();
    compare(obs_main());
    push("ch1_idle", st(4'h0, 4'h0, 4'hF, 4'h0));
    tick();
    compare(obs_main());

    // Busy-bounded drain on ch2 (timeout 10 never reached)
    m.timeout_cfg = 8'd10;
    m.ip_enable[2] = 1'b1;
    push("ch2_enable", st(4'h4, 4'h0, 4'hB, 4'h0));
    tick();
    m.ip_enable[2] = 1'b0;
    compare(obs_main());
    m.busy[2] = 1'b1;
    m.req_disable[2] = 1'b1;
    push("ch2_drain0", st(4'h4, 4'h0, 4'hB, 4'h0));
    tick();
    m.req_disable[2] = 1'b0;
    compare(obs_main());
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("ch2_drain%0d", k), st(4'h4, 4'h0, 4'hB, 4'h0));
      tick();
      compare(obs_main());
    end
    m.busy[2] = 1'b0;
    push("ch2_ack", st(4'h0, 4'h4, 4'hB, 4'h0));
    tick();
    compare(obs_main());
    push("ch2_idle", st(4'h0, 4'h0, 4'hF, 4'h0));
    tick();
    compare(obs_main());

    // Timeout on ch3 with timeout_cfg=4: exactly 4 DRAIN cycles
    m.timeout_cfg = 8'd4;
    m.ip_enable[3] = 1'b1;
    push("ch3_enable", st(4'h8, 4'h0, 4'h7, 4'h0));
    tick();
    m.ip_enable[3] = 1'b0;
    compare(obs_main());
    m.busy[3] = 1'b1;
    m.req_disable[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push($sformatf("ch3_drain%0d", k), st(4'h8, 4'h0, 4'h7, 4'h0));
      tick();
      m.req_disable[3] = 1'b0;
      compare(obs_main());
    end
    push("ch3_to_ack", st(4'h0, 4'h8, 4'h7, 4'h8));
    tick();
    compare(obs_main());
    push("ch3_err_sticky", st(4'h0, 4'h0, 4'hF, 4'h8));
    tick();
    compare(obs_main());
    m.err_clr[3] = 1'b1;
    push("ch3_err_clr", st(4'h0, 4'h0, 4'hF, 4'h0));
    tick();
    m.err_clr[3] = 1'b0;
    compare(obs_main());

    // Second timeout with err_clr coincident: set wins
    m.ip_enable[3] = 1'b1;
    push("ch3_reenable", st(4'h8, 4'h0, 4'h7, 4'h0));
    tick();
    m.ip_enable[3] = 1'b0;
    compare(obs_main());
    m.req_disable[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push($sformatf("ch3b_drain%0d", k), st(4'h8, 4'h0, 4'h7, 4'h0));
      tick();
      m.req_disable[3] = 1'b0;
      compare(obs_main());
    end
    m.err_clr[3] = 1'b1;
    push("ch3_set_wins", st(4'h0, 4'h8, 4'h7, 4'h8));
    tick();
    m.err_clr[3] = 1'b0;
    m.busy[3] = 1'b0;
    compare(obs_main());
    push("ch3b_idle", st(4'h0, 4'h0, 4'hF, 4'h8));
    tick();
    compare(obs_main());

    // ch0: enable and disable together, ip_enable held through DISABLE
    m.ip_enable[0] = 1'b1;
    m.req_disable[0] = 1'b1;
    push("both_in_idle", st(4'h1, 4'h0, 4'hE, 4'h8));
    tick();
    compare(obs_main());
    push("both_in_enable", st(4'h1, 4'h0, 4'hE, 4'h8));
    tick();
    m.req_disable[0] = 1'b0;
    compare(obs_main());
    push("ch0_ack", st(4'h0, 4'h1, 4'hE, 4'h8));
    tick();
    compare(obs_main());
    push("ch0_idle_held", st(4'h0, 4'h0, 4'hF, 4'h8));
    tick();
    compare(obs_main());
    push("ch0_reenable", st(4'h1, 4'h0, 4'hE, 4'h8));
    tick();
    m.ip_enable[0] = 1'b0;
    compare(obs_main());

    // All channels disabling together (ch0 already enabled)
    m.ip_enable = 4'hF;
    push("all_enable", st(4'hF, 4'h0, 4'h0, 4'h8));
    tick();
    m.ip_enable = 4'h0;
    compare(obs_main());
    m.req_disable = 4'hF;
    push("all_drain", st(4'hF, 4'h0, 4'h0, 4'h8));
    tick();
    m.req_disable = 4'h0;
    compare(obs_main());
    push("all_ack", st(4'h0, 4'hF, 4'h0, 4'h8));
    tick();
    compare(obs_main());
    push("all_idle", st(4'h0, 4'h0, 4'hF, 4'h8));
    tick();
    compare(obs_main());

    // Async reset mid-drain on ch0 with busy held
    m.timeout_cfg = 8'd0;
    m.ip_enable[0] = 1'b1;
    tick();
    m.ip_enable[0] = 1'b0;
    m.busy[0] = 1'b1;
    m.req_disable[0] = 1'b1;
    push("pre_reset_drain", st(4'h1, 4'h0, 4'hE, 4'h8));
    tick();
    m.req_disable[0] = 1'b0;
    compare(obs_main());
    @(negedge clk);
    rst = 1'b1;
    #1;
    push("async_reset", st(4'h0, 4'h0, 4'hF, 4'h0));
    compare(obs_main());
    tick();
    rst = 1'b0;
    m.busy[0] = 1'b0;
    push("post_reset", st(4'h0, 4'h0, 4'hF, 4'h0));
    tick();
    compare(obs_main());

    // TO_W=4 instance: unbounded drain saturates the counter without wrap
    m4.timeout_cfg = 4'd0;
    m4.ip_enable = 1'b1;
    tick();
    m4.ip_enable = 1'b0;
    m4.busy = 1'b1;
    m4.req_disable = 1'b1;
    tick();
    m4.req_disable = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k % 10 == 0) push($sformatf("sat_drain%0d", k), st1(1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      if (k % 10 == 0) compare(obs_small());
    end
    // cfg=15 can only match cnt==14, which a saturated counter never revisits
    m4.timeout_cfg = 4'd15;
    repeat (20) tick();
    push("sat_no_wrap", st1(1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    compare(obs_small());
    m4.busy = 1'b0;
    push("sat_ack", st1(1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    compare(obs_small());
    push("sat_idle", st1(1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    compare(obs_small());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_chan_enable_ctrl.md
Name: fsm_chan_enable_ctrl

Overview:
Multi-channel enable/disable handshake controller. Each of NUM_CH channels runs an independent four-state FSM: enable request, disable request, bounded drain wait, one-cycle disable acknowledge. It sits between a control/register block and NUM_CH IP datapaths, and gates each datapath's enable. It also reports per-channel idle status, drain-timeout errors and an aggregate all-idle flag.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
TO_W, 8, width of drain-timeout counter and timeout_cfg

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high; clears all state
ip_enable  in  NUM_CH  per-channel enable request, level-sampled
req_disable  in  NUM_CH  per-channel disable request, level-sampled
busy  in  NUM_CH  per-channel datapath still has work in flight
timeout_cfg  in  TO_W  drain timeout in cycles, shared by all channels; 0 = no timeout
err_clr  in  NUM_CH  per-channel clear of sticky timeout_err
enabled  out  NUM_CH  channel datapath enable
ack  out  NUM_CH  one-cycle disable-complete pulse
idle  out  NUM_CH  channel in IDLE
timeout_err  out  NUM_CH  sticky: drain ended by timeout
all_idle  out  1  AND of idle[NUM_CH-1:0]

Behaviour:
- Reset state (async assert, any cycle, including mid-drain): all channels IDLE, cnt=0, enabled=0, ack=0, idle=all 1s, timeout_err=0, all_idle=1. Deassertion is synchronous to clk.
- Per-channel state encoding: IDLE=2'b00, ENABLE=2'b01, DRAIN=2'b10, DISABLE=2'b11. Channels are fully independent and share only timeout_cfg.
- Transitions, one per clk edge:
  - IDLE: ip_enable=1 -> ENABLE; else stay. req_disable is ignored in IDLE.
  - ENABLE: req_disable=1 -> DRAIN, cnt<=0; else stay. ip_enable is ignored. Disable wins if both are high.
  - DRAIN: busy=0 -> DISABLE. Else if timeout_cfg!=0 and cnt==timeout_cfg-1 -> DISABLE and set timeout_err. Else stay, cnt<=cnt+1.
  - DISABLE: -> IDLE unconditionally.
  - Illegal/unreached encodings: none exist with 2 bits; default branch -> IDLE.
- DRAIN lasts at least 1 cycle, even if busy=0 on entry.
- Timeout of N (N>0): at most N cycles in DRAIN.
- timeout_cfg=0: wait indefinitely for busy=0. cnt saturates at all-ones and never wraps.
- timeout_cfg is sampled every DRAIN cycle. A change mid-drain takes effect immediately. If the new value is <= cnt, the channel waits for busy=0, or cnt saturation is not treated as a timeout.
- Outputs are Moore, decoded from registered state:
  - IDLE: idle=1
  - ENABLE: enabled=1
  - DRAIN: enabled=1, because the datapath keeps running to drain
  - DISABLE: ack=1
  - All other outputs are 0 in each state.
- Latencies:
  - ack asserts exactly 1 cycle after leaving DRAIN.
  - idle asserts the cycle after ack.
  - Full disable sequence from req_disable sampled, with busy already 0: DRAIN 1 cycle, DISABLE 1 cycle, then IDLE.
- timeout_err is sticky, registered. err_clr=1 clears it the next cycle. A set and a clear in the same cycle leave it at 1 (set wins).
- ip_enable held high through DISABLE re-enables: the channel goes IDLE then ENABLE on the following edge. There is no IDLE->ENABLE bypass.
- all_idle is combinational AND of idle.

Test Plan:
- Reset: assert rst mid-cycle with ch0 in DRAIN and busy=1 -> all outputs immediately return to reset values (idle=4'hF, enabled=0, ack=0, timeout_err=0, all_idle=1).
- Basic handshake, ch1: ip_enable pulse -> enabled[1]=1 next cycle. Then req_disable with busy=0 -> 1 cycle DRAIN, ack[1]=1 for exactly 1 cycle, then idle[1]=1. No other channel changes.
- Busy-bounded drain: timeout_cfg=10, busy[2]=1 for 5 cycles after DRAIN entry then 0 -> ack[2] on cycle 7 after req_disable sampled, timeout_err[2]=0.
- Timeout: timeout_cfg=4, busy[3] held 1 -> exactly 4 DRAIN cycles, then ack[3] and timeout_err[3]=1. err_clr[3] pulse clears it. err_clr coincident with a new timeout leaves it at 1.
- No-timeout boundary: timeout_cfg=0, TO_W=4 build, busy held 1 for 40 cycles -> channel stays in DRAIN with cnt saturated at 15, no timeout_err. busy=0 -> normal ack.
- Simultaneous and independent events:
  - ip_enable and req_disable both high in IDLE -> ENABLE.
  - Both high in ENABLE -> DRAIN.
  - All 4 channels disabling in the same cycle -> 4 concurrent ack pulses, all_idle=1 the next cycle.
